// File: rtl/hub75_capture.sv
// HUB75 receive-side capture: oversamples the panel interface on clk and rebuilds
// the panel's shift registers and row latches into a readable 16x32 RGB frame store.
module hub75_capture #(
   parameter int WIDTH       = 32,
   parameter int ROWS        = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] rgb,
   input  logic       lat,
   input  logic       oe,
   input  logic [2:0] abc,
   input  logic       outclk,
   input  logic [3:0] rd_row,
   input  logic [4:0] rd_col,
   output logic [2:0] rd_pix,
   output logic       frame_done,
   output logic [7:0] frame_count,
   output logic [2:0] cur_row,
   output logic       short_err,
   output logic       latch_err
);
   localparam int         SCAN     = ROWS / 2;
   localparam logic [5:0] CNT_MAX  = 6'd63;
   localparam logic [5:0] CNT_ROW  = 6'(WIDTH);
   localparam logic [2:0] LAST_ROW = 3'(SCAN - 1);

   logic [SYNC_STAGES-1:0][11:0]     r_sync;
   logic                             r_outclk_d;
   logic                             r_lat_d;
   logic [5:0][WIDTH-1:0]            r_sr;
   logic [5:0]                       r_shift_cnt;
   logic [SCAN-1:0]                  r_mask;
   logic [ROWS-1:0][WIDTH-1:0][2:0]  r_store;
   logic [2:0]                       r_rd_pix;
   logic                             r_frame_done;
   logic [7:0]                       r_frame_count;
   logic [2:0]                       r_cur_row;
   logic                             r_short_err;
   logic                             r_latch_err;

   logic [11:0]           w_in;
   logic [11:0]           w_s;
   logic [5:0]            w_rgb;
   logic                  w_lat;
   logic                  w_oe;
   logic [2:0]            w_abc;
   logic                  w_outclk;
   logic                  w_shift;
   logic                  w_latch;
   logic [5:0][WIDTH-1:0] w_sr_nxt;
   logic [5:0]            w_cnt_nxt;
   logic [SCAN-1:0]       w_mask_set;
   logic                  w_complete;
   logic [3:0]            w_row_top;
   logic [3:0]            w_row_bot;

   // All twelve HUB75 bits share one synchroniser chain so they stay aligned.
   assign w_in     = {rgb, lat, oe, abc, outclk};
   assign w_s      = r_sync[SYNC_STAGES-1];
   assign w_rgb    = w_s[11:6];
   assign w_lat    = w_s[5];
   assign w_oe     = w_s[4];
   assign w_abc    = w_s[3:1];
   assign w_outclk = w_s[0];

   assign w_shift    = w_outclk & ~r_outclk_d;
   assign w_latch    = w_lat & ~r_lat_d;
   assign w_mask_set = r_mask | (SCAN'(1) << w_abc);
   assign w_complete = (w_abc == LAST_ROW) && (&w_mask_set);
   assign w_row_top  = {1'b0, w_abc};
   assign w_row_bot  = {1'b1, w_abc};
   assign w_cnt_nxt  = (w_shift && r_shift_cnt != CNT_MAX) ? r_shift_cnt + 6'd1 : r_shift_cnt;

   // Latch sees the post-shift registers when outclk and lat rise together.
   always_comb begin
      w_sr_nxt = r_sr;
      if (w_shift)
         for (int i = 0; i < 6; i++)
            w_sr_nxt[i] = {r_sr[i][WIDTH-2:0], w_rgb[i]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync      <= '0;
         r_outclk_d  <= 1'b0;
         r_lat_d     <= 1'b0;
         r_sr        <= '0;
         r_shift_cnt <= '0;
      end else begin
         r_sync[0] <= w_in;
         for (int i = 1; i < SYNC_STAGES; i++)
            r_sync[i] <= r_sync[i-1];
         r_outclk_d  <= w_outclk;
         r_lat_d     <= w_lat;
         r_sr        <= w_sr_nxt;
         r_shift_cnt <= w_latch ? 6'd0 : w_cnt_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mask        <= '0;
         r_frame_done  <= 1'b0;
         r_frame_count <= '0;
         r_cur_row     <= '0;
         r_short_err   <= 1'b0;
         r_latch_err   <= 1'b0;
      end else begin
         r_frame_done <= w_latch & w_complete;
         if (w_latch) begin
            r_cur_row <= w_abc;
            if (w_cnt_nxt < CNT_ROW) r_short_err <= 1'b1;
            if (!w_oe)               r_latch_err <= 1'b1;
            // Any latch of the last row resyncs the mask, complete or not.
            if (w_abc == LAST_ROW) r_mask <= '0;
            else                   r_mask <= w_mask_set;
            if (w_complete) r_frame_count <= r_frame_count + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_store <= '0;
      end else if (w_latch) begin
         for (int c = 0; c < WIDTH; c++) begin
            r_store[w_row_top][c] <= {w_sr_nxt[5][WIDTH-1-c], w_sr_nxt[4][WIDTH-1-c], w_sr_nxt[3][WIDTH-1-c]};
            r_store[w_row_bot][c] <= {w_sr_nxt[2][WIDTH-1-c], w_sr_nxt[1][WIDTH-1-c], w_sr_nxt[0][WIDTH-1-c]};
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_rd_pix <= '0;
      else       r_rd_pix <= r_store[rd_row][rd_col];
   end

   assign rd_pix      = r_rd_pix;
   assign frame_done  = r_frame_done;
   assign frame_count = r_frame_count;
   assign cur_row     = r_cur_row;
   assign short_err   = r_short_err;
   assign latch_err   = r_latch_err;
endmodule

// File: tb/tb_hub75_capture.sv
// Directed bench for hub75_capture: drives HUB75 rows/frames and checks the
// frame store, frame counter and error flags against hand-computed values.
module tb_hub75_capture;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] rgb = '0;
   logic       lat = 1'b0;
   logic       oe = 1'b1;
   logic [2:0] abc = '0;
   logic       outclk = 1'b0;
   logic [3:0] rd_row = '0;
   logic [4:0] rd_col = '0;
   logic [2:0] rd_pix;
   logic       frame_done;
   logic [7:0] frame_count;
   logic [2:0] cur_row;
   logic       short_err;
   logic       latch_err;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   hub75_capture dut (
      .clk(clk), .reset(reset), .rgb(rgb), .lat(lat), .oe(oe), .abc(abc),
      .outclk(outclk), .rd_row(rd_row), .rd_col(rd_col), .rd_pix(rd_pix),
      .frame_done(frame_done), .frame_count(frame_count), .cur_row(cur_row),
      .short_err(short_err), .latch_err(latch_err)
   );

   always #5 clk = ~clk;
   always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic shift_px(input logic [5:0] v);
      rgb = v; outclk = 1'b0; cyc(2);
      outclk = 1'b1; cyc(2);
   endtask

   task automatic latch_row(input logic [2:0] a);
      abc = a; cyc(4);
      lat = 1'b1; cyc(3);
      lat = 1'b0; cyc(4);
   endtask

   task automatic read_px(input int r, input int c, output logic [2:0] p);
      rd_row = 4'(r); rd_col = 5'(c); cyc(2);
      p = rd_pix;
   endtask

   task automatic solid_row(input logic [2:0] a, input logic [2:0] col);
      for (int k = 0; k < 32; k++) shift_px({col, col});
      latch_row(a);
   endtask

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, got, exp);
      end
   endtask

   task automatic test_reset;
      logic [2:0] p;
      reset = 1'b1; cyc(3); reset = 1'b0; cyc(3);
      checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", frame_count); end
      checks++; if (short_err !== 1'b0) begin errors++; $display("FAIL reset_short: got %b want 0", short_err); end
      checks++; if (latch_err !== 1'b0) begin errors++; $display("FAIL reset_latch: got %b want 0", latch_err); end
      checks++; if (cur_row !== 3'd0) begin errors++; $display("FAIL reset_row: got %0d want 0", cur_row); end
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 32; c++) begin
            read_px(r, c, p);
            checks++; if (p !== 3'b000) begin errors++; $display("FAIL reset_pix(%0d,%0d): got %b want 000", r, c, p); end
         end
      checks++; if (done_cnt !== 0) begin errors++; $display("FAIL reset_done: got %0d want 0", done_cnt); end
   endtask

   task automatic test_one_row;
      logic [2:0] p, et, eb;
      for (int k = 0; k < 4; k++) shift_px(6'b111111);
      for (int k = 4; k < 36; k++) shift_px(((k - 4) % 2 == 0) ? 6'b100_001 : 6'b000_000);
      latch_row(3'd3);
      for (int c = 0; c < 32; c++) begin
         et = (c % 2 == 0) ? 3'b100 : 3'b000;
         eb = (c % 2 == 0) ? 3'b001 : 3'b000;
         read_px(3, c, p);
         checks++; if (p !== et) begin errors++; $display("FAIL row_top(3,%0d): got %b want %b", c, p, et); end
         read_px(11, c, p);
         checks++; if (p !== eb) begin errors++; $display("FAIL row_bot(11,%0d): got %b want %b", c, p, eb); end
      end
      checks++; if (cur_row !== 3'd3) begin errors++; $display("FAIL row_cur: got %0d want 3", cur_row); end
      checks++; if (short_err !== 1'b0) begin errors++; $display("FAIL row_short: got %b want 0", short_err); end
      checks++; if (done_cnt !== 0) begin errors++; $display("FAIL row_done: got %0d want 0", done_cnt); end
   endtask

   task automatic test_full_frame;
      logic [2:0] p;
      int d0 = done_cnt;
      for (int a = 0; a < 8; a++) solid_row(3'(a), 3'(a + 1));
      checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL frame_done: got %0d want 1", done_cnt - d0); end
      checks++; if (frame_count !== 8'd1) begin errors++; $display("FAIL frame_count: got %0d want 1", frame_count); end
      read_px(5, 17, p);
      checks++; if (p !== 3'b110) begin errors++; $display("FAIL frame_5_17: got %b want 110", p); end
      read_px(13, 0, p);
      checks++; if (p !== 3'b110) begin errors++; $display("FAIL frame_13_0: got %b want 110", p); end
      read_px(0, 31, p);
      checks++; if (p !== 3'b001) begin errors++; $display("FAIL frame_0_31: got %b want 001", p); end
      read_px(7, 3, p);
      checks++; if (p !== 3'b000) begin errors++; $display("FAIL frame_7_3: got %b want 000", p); end
   endtask

   task automatic test_short_row;
      logic [2:0] p, et, eb;
      solid_row(3'd1, 3'b101);
      for (int k = 0; k < 20; k++) begin
         et = 3'(k % 7 + 1);
         shift_px({et, ~et});
      end
      latch_row(3'd2);
      checks++; if (short_err !== 1'b1) begin errors++; $display("FAIL short_err: got %b want 1", short_err); end
      checks++; if (latch_err !== 1'b0) begin errors++; $display("FAIL short_latch: got %b want 0", latch_err); end
      checks++; if (cur_row !== 3'd2) begin errors++; $display("FAIL short_cur: got %0d want 2", cur_row); end
      for (int c = 0; c < 32; c++) begin
         et = (c < 12) ? 3'b101 : 3'((c - 12) % 7 + 1);
         eb = (c < 12) ? 3'b101 : ~3'((c - 12) % 7 + 1);
         read_px(2, c, p);
         checks++; if (p !== et) begin errors++; $display("FAIL short_top(2,%0d): got %b want %b", c, p, et); end
         read_px(10, c, p);
         checks++; if (p !== eb) begin errors++; $display("FAIL short_bot(10,%0d): got %b want %b", c, p, eb); end
      end
   endtask

   task automatic test_oe_and_reset;
      logic [2:0] p;
      for (int k = 0; k < 32; k++) shift_px(6'b010_010);
      oe = 1'b0; latch_row(3'd4); oe = 1'b1;
      checks++; if (latch_err !== 1'b1) begin errors++; $display("FAIL oe_latch_err: got %b want 1", latch_err); end
      read_px(4, 0, p);
      checks++; if (p !== 3'b010) begin errors++; $display("FAIL oe_row_4_0: got %b want 010", p); end
      read_px(12, 31, p);
      checks++; if (p !== 3'b010) begin errors++; $display("FAIL oe_row_12_31: got %b want 010", p); end
      for (int k = 0; k < 10; k++) shift_px(6'b111111);
      reset = 1'b1; outclk = 1'b0; #2;
      checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL async_count: got %0d want 0", frame_count); end
      checks++; if (latch_err !== 1'b0) begin errors++; $display("FAIL async_latch: got %b want 0", latch_err); end
      cyc(2); reset = 1'b0; cyc(2);
      checks++; if (short_err !== 1'b0) begin errors++; $display("FAIL rst_short: got %b want 0", short_err); end
      checks++; if (cur_row !== 3'd0) begin errors++; $display("FAIL rst_cur: got %0d want 0", cur_row); end
      read_px(4, 0, p);
      checks++; if (p !== 3'b000) begin errors++; $display("FAIL rst_pix_4_0: got %b want 000", p); end
      read_px(2, 20, p);
      checks++; if (p !== 3'b000) begin errors++; $display("FAIL rst_pix_2_20: got %b want 000", p); end
      for (int a = 0; a < 8; a++) solid_row(3'(a), 3'(a + 1));
      checks++; if (frame_count !== 8'd1) begin errors++; $display("FAIL rst_frame_count: got %0d want 1", frame_count); end
      checks++; if (short_err !== 1'b0) begin errors++; $display("FAIL rst_frame_short: got %b want 0", short_err); end
      read_px(9, 5, p);
      checks++; if (p !== 3'b010) begin errors++; $display("FAIL rst_frame_9_5: got %b want 010", p); end
   endtask

   task automatic test_out_of_order;
      int d0 = done_cnt;
      for (int a = 5; a < 8; a++) solid_row(3'(a), 3'b011);
      checks++; if (done_cnt !== d0) begin errors++; $display("FAIL ooo_no_done: got %0d want %0d", done_cnt, d0); end
      checks++; if (frame_count !== 8'd1) begin errors++; $display("FAIL ooo_count1: got %0d want 1", frame_count); end
      for (int a = 0; a < 8; a++) solid_row(3'(a), 3'b011);
      checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL ooo_done: got %0d want %0d", done_cnt, d0 + 1); end
      checks++; if (frame_count !== 8'd2) begin errors++; $display("FAIL ooo_count2: got %0d want 2", frame_count); end
   endtask

   task automatic test_wrap;
      int d0 = done_cnt;
      for (int f = 0; f < 254; f++)
         for (int a = 0; a < 8; a++) latch_row(3'(a));
      checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL wrap_count: got %0d want 0", frame_count); end
      checks++; if (done_cnt !== d0 + 254) begin errors++; $display("FAIL wrap_done: got %0d want %0d", done_cnt, d0 + 254); end
      checks++; if (short_err !== 1'b1) begin errors++; $display("FAIL wrap_short: got %b want 1", short_err); end
   endtask

   initial begin
      test_reset();
      test_one_row();
      test_full_frame();
      test_short_row();
      test_oe_and_reset();
      test_out_of_order();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
